// File: rtl/lift_pkg.sv
// Shared encodings for the lift motion controller: direction requests,
// controller states and latched fault codes.
package lift_pkg;

  typedef enum logic [1:0] {
    DIR_STOP   = 2'b00,
    DIR_DOWN   = 2'b01,
    DIR_UP     = 2'b10,
    DIR_UPDOWN = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MOVING = 2'b01,
    ST_DOOR   = 2'b10,
    ST_FAULT  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    FLT_NONE   = 2'b00,
    FLT_TOP    = 2'b01,
    FLT_BOTTOM = 2'b10,
    FLT_UPDOWN = 2'b11
  } fault_t;

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter that saturates at zero; freeze holds the count.
module lift_timer #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               freeze,
  output logic               zero
);

  logic [COUNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (!freeze && count != '0) begin
      count <= count - COUNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lift_motion_ctrl.sv
// Single-car motion sequencer: one-floor moves with fixed travel time, a
// mandatory door dwell after each arrival, and a latched fault on illegal moves.
module lift_motion_ctrl
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS   = 7,
  parameter int BOTTOM_FLOOR = 1,
  parameter int FLOOR_W      = 3,
  parameter int CLK_PER_MOVE = 1000000000,
  parameter int CLK_PER_DOOR = 10000000,
  parameter int COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         dir,
  input  logic               hold,
  input  logic               estop,
  input  logic               fault_clear,
  output logic [FLOOR_W-1:0] floor,
  output logic [FLOOR_W-1:0] next_floor,
  output logic               moving,
  output logic               door_open,
  output logic               arrive,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [1:0]         state
);

  localparam logic [FLOOR_W-1:0] BOT_FLOOR = FLOOR_W'(BOTTOM_FLOOR);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(BOTTOM_FLOOR + NUM_FLOORS - 1);
  localparam logic [COUNT_W-1:0] MOVE_LOAD = COUNT_W'(CLK_PER_MOVE - 1);
  localparam logic [COUNT_W-1:0] DOOR_LOAD = COUNT_W'(CLK_PER_DOOR - 1);

  state_t             state_q;
  fault_t             code_q;
  dir_t               dir_in;
  logic               start_move;
  logic               arrive_now;
  logic               timer_load;
  logic [COUNT_W-1:0] timer_val;
  logic               timer_freeze;
  logic               timer_zero;

  assign dir_in = dir_t'(dir);

  // hold outranks any direction request while idle
  assign start_move = !hold &&
                      ((dir_in == DIR_UP   && floor < TOP_FLOOR) ||
                       (dir_in == DIR_DOWN && floor > BOT_FLOOR));
  assign arrive_now = (state_q == ST_MOVING) && timer_zero && !estop;

  always_comb begin
    timer_load   = 1'b0;
    timer_val    = DOOR_LOAD;
    timer_freeze = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold) begin
          timer_load = 1'b1;
        end else if (start_move) begin
          timer_load = 1'b1;
          timer_val  = MOVE_LOAD;
        end
      end
      ST_MOVING: begin
        timer_freeze = estop;
        timer_load   = arrive_now;
      end
      ST_DOOR:  timer_load = hold;
      default:  timer_freeze = 1'b1;
    endcase
  end

  lift_timer #(.COUNT_W(COUNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_val),
    .freeze     (timer_freeze),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      floor      <= BOT_FLOOR;
      next_floor <= BOT_FLOOR;
      moving     <= 1'b0;
      door_open  <= 1'b0;
      arrive     <= 1'b0;
      fault      <= 1'b0;
      code_q     <= FLT_NONE;
    end else begin
      arrive <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hold) begin
            state_q   <= ST_DOOR;
            door_open <= 1'b1;
          end else if (start_move) begin
            state_q    <= ST_MOVING;
            moving     <= 1'b1;
            next_floor <= (dir_in == DIR_UP) ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
          end else if (dir_in != DIR_STOP) begin
            state_q <= ST_FAULT;
            fault   <= 1'b1;
            code_q  <= (dir_in == DIR_UPDOWN) ? FLT_UPDOWN :
                       (dir_in == DIR_UP)     ? FLT_TOP : FLT_BOTTOM;
          end
        end
        ST_MOVING: begin
          if (arrive_now) begin
            state_q   <= ST_DOOR;
            floor     <= next_floor;
            arrive    <= 1'b1;
            moving    <= 1'b0;
            door_open <= 1'b1;
          end
        end
        ST_DOOR: begin
          if (timer_zero && !hold) begin
            state_q   <= ST_IDLE;
            door_open <= 1'b0;
          end
        end
        default: begin
          if (fault_clear) begin
            state_q <= ST_IDLE;
            fault   <= 1'b0;
            code_q  <= FLT_NONE;
          end
        end
      endcase
    end
  end

  assign state      = state_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// Self-checking bench for lift_motion_ctrl: directed scenarios plus random
// traffic compared against a phase/remaining-cycles model of the car.
module tb_lift_motion_ctrl;

  localparam int NF = 7;
  localparam int BF = 1;
  localparam int FW = 3;
  localparam int CM = 4;
  localparam int CD = 3;
  localparam int CW = 32;
  localparam int TOP = BF + NF - 1;

  // clock / reset block
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    dir = 2'b00;
  logic          hold = 1'b0;
  logic          estop = 1'b0;
  logic          fault_clear = 1'b0;
  logic [FW-1:0] floor;
  logic [FW-1:0] next_floor;
  logic          moving;
  logic          door_open;
  logic          arrive;
  logic          fault;
  logic [1:0]    fault_code;
  logic [1:0]    state;

  always #5 clk = ~clk;

  lift_motion_ctrl #(
    .NUM_FLOORS   (NF),
    .BOTTOM_FLOOR (BF),
    .FLOOR_W      (FW),
    .CLK_PER_MOVE (CM),
    .CLK_PER_DOOR (CD),
    .COUNT_W      (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dir         (dir),
    .hold        (hold),
    .estop       (estop),
    .fault_clear (fault_clear),
    .floor       (floor),
    .next_floor  (next_floor),
    .moving      (moving),
    .door_open   (door_open),
    .arrive      (arrive),
    .fault       (fault),
    .fault_code  (fault_code),
    .state       (state)
  );

  int checks = 0;
  int failures = 0;
  logic [FW-1:0] exp_q[$];

  // reference model: phase 0 idle, 1 travel, 2 dwell, 3 fault;
  // m_left counts visible cycles still remaining in the current phase
  int m_phase;
  int m_floor;
  int m_target;
  int m_left;
  int m_code;
  bit m_arrive;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [1:0] d, input logic h,
                            input logic e, input logic fc);
    m_arrive = 1'b0;
    if (rst) begin
      m_phase = 0; m_floor = BF; m_target = BF; m_left = 0; m_code = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: begin
          if (h) begin
            m_phase = 2; m_left = CD;
          end else if (d == 2'b10) begin
            if (m_floor < TOP) begin m_phase = 1; m_target = m_floor + 1; m_left = CM; end
            else begin m_phase = 3; m_code = 1; end
          end else if (d == 2'b01) begin
            if (m_floor > BF) begin m_phase = 1; m_target = m_floor - 1; m_left = CM; end
            else begin m_phase = 3; m_code = 2; end
          end else if (d == 2'b11) begin
            m_phase = 3; m_code = 3;
          end
        end
        1: begin
          if (!e) begin
            if (m_left == 1) begin
              m_floor = m_target; m_arrive = 1'b1; m_phase = 2; m_left = CD;
              exp_q.push_back(FW'(m_floor));
            end else begin
              m_left--;
            end
          end
        end
        2: begin
          if (h) m_left = CD;
          else if (m_left == 1) m_phase = 0;
          else m_left--;
        end
        default: begin
          if (fc) begin m_phase = 0; m_code = 0; end
        end
      endcase
    end
    if (m_phase != 1) m_target = m_floor;
  endtask

  task automatic compare_all();
    check("floor", floor, m_floor);
    check("next_floor", next_floor, m_target);
    check("moving", moving, m_phase == 1);
    check("door_open", door_open, m_phase == 2);
    check("arrive", arrive, m_arrive);
    check("fault", fault, m_phase == 3);
    check("fault_code", fault_code, m_code);
    check("state", state, m_phase);
    if (arrive === 1'b1) begin
      check("arrive_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("arrive_floor_sb", floor, exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic do_cycle(input logic [1:0] d, input logic h, input logic e,
                          input logic fc, input logic rst);
    dir = d; hold = h; estop = e; fault_clear = fc; reset = rst;
    model_step(rst, d, h, e, fc);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_cycle();
    do_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (state !== 2'b00 && g < 100) begin
      idle_cycle();
      g++;
    end
    check("idle_reached", state, 0);
  endtask

  task automatic step_up();
    do_cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic do_reset();
    do_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    do_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    int i;
    int r;
    logic [1:0] d;

    do_reset();
    check("reset_floor", floor, BF);
    check("reset_state", state, 0);

    // one floor up: 4 travel cycles, arrival at 2, 3 dwell cycles
    do_cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    check("first_next_floor", next_floor, 2);
    n = 0;
    while (moving === 1'b1 && n < 50) begin n++; idle_cycle(); end
    check("move_len", n, CM);
    check("arrive_with_door", {arrive, door_open}, 2'b11);
    check("arrived_floor", floor, 2);
    n = 0;
    while (door_open === 1'b1 && n < 50) begin n++; idle_cycle(); end
    check("door_len", n, CD);
    check("back_idle", state, 0);

    // DOWN at bottom faults, fault_clear recovers
    do_reset();
    do_cycle(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bottom_fault_code", fault_code, 2);
    check("bottom_fault_floor", floor, 1);
    do_cycle(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clear_fault", fault, 0);

    // climb to the top, then UP and UPDOWN faults
    repeat (6) step_up();
    check("top_floor", floor, TOP);
    do_cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    check("top_fault_code", fault_code, 1);
    do_cycle(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    do_cycle(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    check("updown_fault_code", fault_code, 3);
    do_cycle(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    // estop for 5 cycles mid-travel stretches the move to 9 cycles
    do_reset();
    do_cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    i = 0;
    while (moving === 1'b1 && n < 50) begin
      n++;
      do_cycle(2'b00, 1'b0, (i >= 1 && i <= 5), 1'b0, 1'b0);
      i++;
    end
    check("estop_move_len", n, CM + 5);
    check("estop_arrive", arrive, 1);

    // hold for 6 dwell cycles, then the door closes 3 cycles later
    repeat (6) do_cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (door_open === 1'b1 && n < 50) begin n++; idle_cycle(); end
    check("hold_tail", n, CD);
    do_cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_hold_door", {moving, door_open}, 2'b01);
    wait_idle();

    // reset during travel 4 -> 5
    do_reset();
    repeat (3) step_up();
    do_cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    check("mid_move_target", next_floor, 5);
    do_cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("abort_floor", floor, BF);
    check("abort_outputs", {moving, door_open, arrive, fault, state}, 0);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      r = $urandom_range(0, 9);
      d = (r < 4) ? 2'b00 : (r < 7) ? 2'b10 : (r < 9) ? 2'b01 : 2'b11;
      do_cycle(d, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
    end
    check("arrive_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
